// File: rtl/demux1to4_buf.sv
// Buffered 1-to-4 demux: one-entry register per channel, 1-cycle latency, no comb in->out path.
// in_ready is combinational; a stalled channel blocks only its own traffic and broadcasts.
module demux1to4_buf #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_bcast,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [2:0]         pending
);

  logic [3:0]            full_q, full_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [2:0]            pending_q, pending_d;
  logic [3:0]            free;
  logic [3:0]            load;
  logic                  accept;

  // A full channel being drained this cycle can take a new word in the same edge.
  always_comb begin
    free     = ~full_q | out_ready;
    in_ready = in_bcast ? (&free) : free[in_sel];
    accept   = in_valid & in_ready;
  end

  always_comb begin
    load      = '0;
    full_d    = full_q;
    data_d    = data_q;
    pending_d = '0;
    for (int i = 0; i < 4; i++) begin
      load[i]   = accept & (in_bcast | (in_sel == 2'(i)));
      full_d[i] = load[i] | (full_q[i] & ~out_ready[i]);
      if (load[i]) begin
        data_d[i] = in_data;
      end
      pending_d = pending_d + {2'b00, full_d[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: directed scenarios plus random traffic against a queue-based model.
module tb_demux1to4_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [95:0] out_data;
  logic [2:0]  pending;

  int tests = 0;
  int fails = 0;

  // Reference: each channel is a queue of at most one word; mlast is what the port shows.
  logic [23:0] mq [4][$];
  logic [23:0] mlast [4];

  demux1to4_buf #(.WIDTH(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic bit m_free(int i);
    return (mq[i].size() == 0) || out_ready[i];
  endfunction

  function automatic bit m_ready();
    if (in_bcast) return m_free(0) && m_free(1) && m_free(2) && m_free(3);
    return m_free(int'(in_sel));
  endfunction

  function automatic logic [2:0] m_pending();
    int n = 0;
    for (int i = 0; i < 4; i++) n += mq[i].size();
    return 3'(n);
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [95:0] m_data();
    logic [95:0] d;
    for (int i = 0; i < 4; i++) d[i*24 +: 24] = mlast[i];
    return d;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mlast[i] = '0;
    end
  endfunction

  task automatic set_in(input logic v, input logic [23:0] d, input logic [1:0] s,
                        input logic b, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
    #1;
  endtask

  // Advance one clock edge and apply the spec's transfer rules to the model.
  task automatic cycle();
    bit acc;
    acc = in_valid && m_ready();
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
        if (acc && (in_bcast || in_sel == 2'(i))) begin
          mq[i].push_back(in_data);
          mlast[i] = in_data;
        end
      end
    end
    #1;
  endtask

  task automatic drain_all();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b1111);
    cycle();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_clear();
    #3;
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 96'h0 || pending !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h pending=%0d, want 0000/0/0", out_valid, out_data, pending);
    end
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        set_in(1'b0, 24'h0, 2'(s), 1'(b), 4'b0000);
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL reset_in_ready sel=%0d bcast=%0d: got %b want 1", s, b, in_ready);
        end
      end
    end
  endtask

  task automatic test_single();
    set_in(1'b1, 24'hABCDEF, 2'd2, 1'b0, 4'b0000);
    cycle();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (out_valid !== 4'b0100 || out_data[71:48] !== 24'hABCDEF || pending !== 3'd1) begin
      fails++;
      $display("FAIL single_word: valid=%b ch2=%h pending=%0d, want 0100/abcdef/1", out_valid, out_data[71:48], pending);
    end
    repeat (3) cycle();
    tests++;
    if (out_valid !== 4'b0100) begin
      fails++;
      $display("FAIL single_hold: valid=%b want 0100", out_valid);
    end
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0100);
    cycle();
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0 || out_data[71:48] !== 24'hABCDEF) begin
      fails++;
      $display("FAIL single_drain: valid=%b pending=%0d ch2=%h, want 0000/0/abcdef", out_valid, pending, out_data[71:48]);
    end
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
  endtask

  task automatic test_backpressure();
    set_in(1'b1, 24'h000777, 2'd1, 1'b0, 4'b0000);
    cycle();
    set_in(1'b0, 24'h0, 2'd1, 1'b0, 4'b0000);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_blocked_ch1: in_ready=%b want 0", in_ready);
    end
    set_in(1'b0, 24'h0, 2'd0, 1'b1, 4'b0000);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_blocked_bcast: in_ready=%b want 0", in_ready);
    end
    set_in(1'b1, 24'h000123, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_open_ch0: in_ready=%b want 1", in_ready);
    end
    cycle();
    set_in(1'b1, 24'h000999, 2'd1, 1'b0, 4'b0000);
    cycle();
    tests++;
    if (pending !== 3'd2 || out_valid !== 4'b0011 || out_data[23:0] !== 24'h000123 || out_data[47:24] !== 24'h000777) begin
      fails++;
      $display("FAIL bp_isolation: pending=%0d valid=%b ch0=%h ch1=%h, want 2/0011/000123/000777",
               pending, out_valid, out_data[23:0], out_data[47:24]);
    end
    drain_all();
  endtask

  task automatic test_passthrough();
    set_in(1'b1, 24'h111111, 2'd3, 1'b0, 4'b0000);
    cycle();
    set_in(1'b1, 24'h222222, 2'd3, 1'b0, 4'b1000);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL passthru_ready: in_ready=%b want 1", in_ready);
    end
    cycle();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (out_valid[3] !== 1'b1 || out_data[95:72] !== 24'h222222 || pending !== 3'd1) begin
      fails++;
      $display("FAIL passthru_refill: valid3=%b ch3=%h pending=%0d, want 1/222222/1", out_valid[3], out_data[95:72], pending);
    end
    drain_all();
  endtask

  task automatic test_broadcast();
    set_in(1'b1, 24'h0AAAAA, 2'd0, 1'b0, 4'b0000);
    cycle();
    set_in(1'b1, 24'h5A5A5A, 2'd2, 1'b1, 4'b0000);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bcast_gated: in_ready=%b want 0", in_ready);
    end
    cycle();
    tests++;
    if (out_valid !== 4'b0001 || out_data[23:0] !== 24'h0AAAAA || pending !== 3'd1) begin
      fails++;
      $display("FAIL bcast_no_partial: valid=%b ch0=%h pending=%0d, want 0001/0aaaaa/1", out_valid, out_data[23:0], pending);
    end
    set_in(1'b1, 24'h5A5A5A, 2'd2, 1'b1, 4'b0001);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bcast_open: in_ready=%b want 1", in_ready);
    end
    cycle();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (out_valid !== 4'b1111 || out_data !== {4{24'h5A5A5A}} || pending !== 3'd4) begin
      fails++;
      $display("FAIL bcast_all: valid=%b data=%h pending=%0d, want 1111/5a5a5a x4/4", out_valid, out_data, pending);
    end
    drain_all();
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      set_in(1'b1, 24'(k), 2'd1, 1'b0, 4'b0010);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready k=%0d: in_ready=%b want 1", k, in_ready);
      end
      cycle();
      tests++;
      if (out_valid[1] !== 1'b1 || out_data[47:24] !== 24'(k) || pending !== 3'd1) begin
        fails++;
        $display("FAIL stream_word k=%0d: valid1=%b ch1=%h pending=%0d", k, out_valid[1], out_data[47:24], pending);
      end
    end
    drain_all();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 24'h300000 + 24'(c), 2'(c), 1'b0, 4'b0000);
      cycle();
    end
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (pending !== 3'd3) begin
      fails++;
      $display("FAIL midrst_setup: pending=%0d want 3", pending);
    end
    reset = 1'b1;
    #2;
    m_clear();
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 96'h0 || pending !== 3'd0) begin
      fails++;
      $display("FAIL midrst_async: valid=%b data=%h pending=%0d, want 0000/0/0", out_valid, out_data, pending);
    end
    set_in(1'b1, 24'hABCDEF, 2'd2, 1'b0, 4'b0000);
    cycle();
    tests++;
    if (out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_no_accept_in_reset: valid=%b want 0000", out_valid);
    end
    reset = 1'b0;
    #1;
    cycle();
    set_in(1'b0, 24'h0, 2'd0, 1'b0, 4'b0000);
    tests++;
    if (out_valid !== 4'b0100 || out_data[71:48] !== 24'hABCDEF || pending !== 3'd1) begin
      fails++;
      $display("FAIL midrst_first_accept: valid=%b ch2=%h pending=%0d, want 0100/abcdef/1", out_valid, out_data[71:48], pending);
    end
    drain_all();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 24'($urandom), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), 4'($urandom));
      tests++;
      if (in_ready !== m_ready()) begin
        fails++;
        $display("FAIL rand_in_ready n=%0d: got %b want %b", n, in_ready, m_ready());
      end
      cycle();
      tests++;
      if (out_valid !== m_valid() || out_data !== m_data() || pending !== m_pending()) begin
        fails++;
        $display("FAIL rand_state n=%0d: valid=%b/%b pending=%0d/%0d data=%h want %h",
                 n, out_valid, m_valid(), pending, m_pending(), out_data, m_data());
      end
    end
    drain_all();
  endtask

  initial begin
    m_clear();
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_passthrough();
    test_broadcast();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
# demux1to4_buf

Buffered 1-to-4 demultiplexer with a valid/ready handshake on every port, the routing counterpart of the datapath's 4-to-1 select muxes. It takes one WIDTH-bit word plus a 2-bit destination select and delivers it into one of four single-entry output registers, or into all four at once in broadcast mode. Each output drains independently under its own handshake. It sits between a single producer (ALU/writeback result) and four consumers (register banks, I/O latches) so that a slow consumer stalls only the traffic addressed to it.

## Interface
- WIDTH, 24, data word width in bits (CPU word size).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a word this cycle.
- in_ready  output  1  block accepts the offered word this cycle (combinational).
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 00 ch0, 01 ch1, 10 ch2, 11 ch3.
- in_bcast  input  1  when 1, in_sel is ignored and the word goes to all four channels.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: consumer i takes its word this cycle.
- out_data  output  4*WIDTH  channel i word on bits [i*WIDTH +: WIDTH].
- pending  output  3  number of channels currently holding a word (0..4).

## Operation
- Each channel i has a one-entry buffer: full flag full[i] (drives out_valid[i]) and register data[i].
- Drain: when full[i] && out_ready[i], the buffer empties at the clock edge unless it is reloaded in the same edge.
- free[i] = ~full[i] | out_ready[i]. A full channel whose consumer is taking its word this cycle counts as free (pass-through refill).
- in_ready when in_bcast=0: free[in_sel]. in_ready does not depend on in_valid.
- in_ready when in_bcast=1: free[0] & free[1] & free[2] & free[3]. A broadcast is all-or-nothing and never partially delivered.
- Accept = in_valid && in_ready. On accept, the target channel(s) load in_data and set full. The other channels are unaffected apart from their own drains.
- A channel that is drained and reloaded in the same cycle ends full, holding the new word.
- out_data[i] is the register output and holds its last value when full[i]=0. It changes only on a load.
- out_ready[i] is ignored while full[i]=0.
- pending = popcount(full), registered consistently with full: it reflects the post-edge state.
- Ordering per channel is strict FIFO of depth 1, so words to the same channel arrive in acceptance order.
- No state machine beyond the four full flags. Data is never dropped or duplicated except by reset.

## Timing
- Reset (asynchronous assert) sets full=0000, all data registers to 0 and pending=0.
- After reset: out_valid=0000, out_data=0, in_ready=1 for any in_sel/in_bcast.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge. A word offered in the reset-release cycle is accepted only on the first rising edge with reset low.
- Latency: a word accepted at edge N is visible on out_valid/out_data from just after edge N. That is one cycle, with no combinational in-to-out path.
- Throughput: one word per clock to any channel whose consumer holds out_ready=1 continuously. A broadcast sustains one per clock only if all four consumers are ready.
- in_ready is combinational from in_sel, in_bcast, full and out_ready. The producer must not make in_valid depend on in_ready.
- Back-pressure: while channel s is full and out_ready[s]=0, in_ready=0 for in_sel=s and for broadcast. Other channels still accept.
- Simultaneous drain of one channel and load of another in the same cycle leaves pending unchanged.

## Test plan
- Reset then single word: in_data=24'hABCDEF, in_sel=10, in_valid=1 for one cycle, out_ready=0000 -> next cycle out_valid=0100, out_data ch2=ABCDEF, pending=1. ch2 then holds until out_ready[2]=1.
- Back-pressure isolation: ch1 full with out_ready[1]=0 -> in_ready=0 for in_sel=01, in_ready=1 for in_sel=00. A word 24'h000123 to ch0 is accepted and pending=2.
- Pass-through refill: ch3 full with 24'h111111, out_ready[3]=1, and new word 24'h222222 to ch3 in the same cycle -> accepted. Next cycle out_valid[3]=1, ch3 data=222222, pending unchanged.
- Broadcast gating: ch0 full and not ready, in_bcast=1 -> in_ready=0 and no channel changes. Raising out_ready[0] -> broadcast 24'h5A5A5A accepted, all four hold 5A5A5A, pending=4.
- Streaming: 8 words 1..8 to ch1 back-to-back with out_ready[1]=1 -> in_ready stays 1 and ch1 presents 1..8 on consecutive cycles in order.
- Reset mid-operation: pending=3, assert reset between edges -> out_valid=0000, out_data=0, pending=0 before the next edge. The first post-release accept behaves as in scenario 1.
